// File: rtl/freelist_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : freelist_alloc_ctrl
// Brief    : Dispatch-to-Freelist allocation controller with in-order grant,
//            registered rename output stage and mispredict recovery sequencing.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef PR
`define PR 6
`endif

module freelist_alloc_ctrl #(
    parameter int INIT_CYCLES = 2,
    parameter int RECOVER_LAT = 3,
    parameter int PR_W        = `PR,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [2:0]             disp_valid,
    input  logic [2:0]             disp_needs_dest,
    output logic [2:0]             disp_grant,
    input  logic [2:0][PR_W-1:0]   FreeReg,
    input  logic [2:0]             FreeRegValid,
    output logic [2:0]             DispatchEN,
    output logic                   BPRecoverEN,
    input  logic                   recover_req,
    output logic                   alloc_valid,
    input  logic                   alloc_ready,
    output logic [2:0]             alloc_slot_en,
    output logic [2:0][PR_W-1:0]   alloc_preg,
    output logic                   recover_busy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int         c_CNT_W      = 8;
    localparam logic [1:0] c_ST_INIT    = 2'd0;
    localparam logic [1:0] c_ST_RUN     = 2'd1;
    localparam logic [1:0] c_ST_RECOVER = 2'd2;

    logic [1:0]             r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_bpRecover;
    logic                   r_allocValid;
    logic [2:0]             r_slotEn;
    logic [2:0][PR_W-1:0]   r_preg;
    logic [STALL_CNT_W-1:0] r_stall;

    logic                   w_flush;
    logic                   w_canIssue;
    logic [1:0]             w_freeCnt;
    logic [1:0]             w_used;
    logic                   w_open;
    logic                   w_need;
    logic [2:0]             w_grant;
    logic [2:0][PR_W-1:0]   w_preg;
    logic [2:0]             w_popEn;

    assign w_flush    = recover_req && (r_state != c_ST_INIT);
    assign w_canIssue = !r_allocValid || alloc_ready;

    // In-order prefix grant; the n-th dest-needing slot takes the n-th free tag.
    always_comb begin
        w_freeCnt = FreeRegValid[0] ? (FreeRegValid[1] ? (FreeRegValid[2] ? 2'd3 : 2'd2) : 2'd1) : 2'd0;
        w_grant   = 3'b000;
        w_preg    = '0;
        w_used    = 2'd0;
        w_need    = 1'b0;
        w_open    = (r_state == c_ST_RUN) && w_canIssue;
        for (int k = 0; k < 3; k++) begin
            w_need = disp_valid[k] & disp_needs_dest[k];
            if (w_open && disp_valid[k] &&
                (({1'b0, w_used} + {2'b00, w_need}) <= {1'b0, w_freeCnt})) begin
                w_grant[k] = 1'b1;
                if (w_need) begin
                    w_preg[k] = FreeReg[w_used];
                    w_used    = w_used + 2'd1;
                end
            end else begin
                w_open = 1'b0;
            end
        end
        case (w_used)
            2'd1:    w_popEn = 3'b001;
            2'd2:    w_popEn = 3'b011;
            2'd3:    w_popEn = 3'b111;
            default: w_popEn = 3'b000;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_INIT;
            r_cnt       <= c_CNT_W'(INIT_CYCLES);
            r_bpRecover <= 1'b0;
        end else begin
            r_bpRecover <= 1'b0;
            if (w_flush) begin
                r_state     <= c_ST_RECOVER;
                r_cnt       <= c_CNT_W'(RECOVER_LAT);
                r_bpRecover <= 1'b1;
            end else if (r_state != c_ST_RUN) begin
                // Leave on the edge where the count reaches zero.
                if (r_cnt <= c_CNT_W'(1)) begin
                    r_state <= c_ST_RUN;
                end
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_allocValid <= 1'b0;
            r_slotEn     <= 3'b000;
            r_preg       <= '0;
        end else if (w_flush) begin
            r_allocValid <= 1'b0;
        end else if (|w_grant) begin
            r_allocValid <= 1'b1;
            r_slotEn     <= w_grant;
            r_preg       <= w_preg;
        end else if (alloc_ready) begin
            r_allocValid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall <= '0;
        end else if ((|disp_valid) && (w_grant != disp_valid) && (r_stall != '1)) begin
            r_stall <= r_stall + STALL_CNT_W'(1);
        end
    end

    assign disp_grant    = w_grant;
    assign DispatchEN    = w_popEn;
    assign BPRecoverEN   = r_bpRecover;
    assign alloc_valid   = r_allocValid;
    assign alloc_slot_en = r_slotEn;
    assign alloc_preg    = r_preg;
    assign recover_busy  = (r_state == c_ST_RECOVER);
    assign stall_cycles  = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_freelist_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_freelist_alloc_ctrl
// Brief    : Directed self-checking bench for freelist_alloc_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freelist_alloc_ctrl;

    localparam int PR_W = 6;

    logic            clock = 1'b0;
    logic            reset;
    logic [2:0]      disp_valid;
    logic [2:0]      disp_needs_dest;
    logic [2:0]      disp_grant;
    logic [2:0][PR_W-1:0] FreeReg;
    logic [2:0]      FreeRegValid;
    logic [2:0]      DispatchEN;
    logic            BPRecoverEN;
    logic            recover_req;
    logic            alloc_valid;
    logic            alloc_ready;
    logic [2:0]      alloc_slot_en;
    logic [2:0][PR_W-1:0] alloc_preg;
    logic            recover_busy;
    logic [15:0]     stall_cycles;

    int checks = 0;
    int failures = 0;

    freelist_alloc_ctrl #(
        .INIT_CYCLES(2), .RECOVER_LAT(3), .PR_W(PR_W), .STALL_CNT_W(16)
    ) dut (
        .clock(clock), .reset(reset),
        .disp_valid(disp_valid), .disp_needs_dest(disp_needs_dest),
        .disp_grant(disp_grant), .FreeReg(FreeReg), .FreeRegValid(FreeRegValid),
        .DispatchEN(DispatchEN), .BPRecoverEN(BPRecoverEN), .recover_req(recover_req),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_slot_en(alloc_slot_en), .alloc_preg(alloc_preg),
        .recover_busy(recover_busy), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; disp_valid = 3'b000; disp_needs_dest = 3'b000;
        FreeRegValid = 3'b000; recover_req = 1'b0; alloc_ready = 1'b1;
        FreeReg[0] = 6'd10; FreeReg[1] = 6'd11; FreeReg[2] = 6'd12;
        tick(); tick();
        checks++;
        if ({alloc_valid, alloc_slot_en, BPRecoverEN, recover_busy} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b want=0", {alloc_valid, alloc_slot_en, BPRecoverEN, recover_busy});
        end
        checks++;
        if (alloc_preg !== '0 || stall_cycles !== 16'd0) begin
            failures++; $display("FAIL reset_data preg=%h stall=%0d want 0/0", alloc_preg, stall_cycles);
        end
        // Release mid-cycle; two INIT cycles must show no grants.
        reset = 1'b1; disp_valid = 3'b111; disp_needs_dest = 3'b111; FreeRegValid = 3'b111;
        for (int i = 0; i < 2; i++) begin
            #1; checks++;
            if (disp_grant !== 3'b000 || DispatchEN !== 3'b000) begin
                failures++; $display("FAIL init_block[%0d] grant=%b pop=%b want 000/000", i, disp_grant, DispatchEN);
            end
            tick();
        end
        checks++;
        if (disp_grant !== 3'b111 || DispatchEN !== 3'b111) begin
            failures++; $display("FAIL first_grant grant=%b pop=%b want 111/111", disp_grant, DispatchEN);
        end
        tick();
        disp_valid = 3'b000;
        checks++;
        if (alloc_valid !== 1'b1 || alloc_slot_en !== 3'b111 ||
            alloc_preg[0] !== 6'd10 || alloc_preg[1] !== 6'd11 || alloc_preg[2] !== 6'd12) begin
            failures++; $display("FAIL first_out v=%b en=%b preg=%h want 1/111/{12,11,10}", alloc_valid, alloc_slot_en, alloc_preg);
        end
        checks++;
        if (stall_cycles !== 16'd2) begin
            failures++; $display("FAIL init_stall got=%0d want 2", stall_cycles);
        end
    endtask

    task automatic test_partial();
        disp_valid = 3'b111; disp_needs_dest = 3'b101; FreeRegValid = 3'b001;
        #1; checks++;
        if (disp_grant !== 3'b011 || DispatchEN !== 3'b001) begin
            failures++; $display("FAIL partial_grant grant=%b pop=%b want 011/001", disp_grant, DispatchEN);
        end
        tick();
        checks++;
        if (alloc_slot_en !== 3'b011 || alloc_preg[0] !== 6'd10 ||
            alloc_preg[1] !== 6'd0 || alloc_preg[2] !== 6'd0) begin
            failures++; $display("FAIL partial_out en=%b preg=%h want 011/{0,0,10}", alloc_slot_en, alloc_preg);
        end
        checks++;
        if (stall_cycles !== 16'd3) begin
            failures++; $display("FAIL partial_stall got=%0d want 3", stall_cycles);
        end
    endtask

    task automatic test_backpressure();
        alloc_ready = 1'b0; disp_needs_dest = 3'b111; FreeRegValid = 3'b111;
        for (int i = 0; i < 3; i++) begin
            #1; checks++;
            if (disp_grant !== 3'b000 || DispatchEN !== 3'b000) begin
                failures++; $display("FAIL bp_block[%0d] grant=%b pop=%b want 000/000", i, disp_grant, DispatchEN);
            end
            tick();
            checks++;
            if (alloc_valid !== 1'b1 || alloc_slot_en !== 3'b011 || alloc_preg[0] !== 6'd10) begin
                failures++; $display("FAIL bp_hold[%0d] v=%b en=%b p0=%0d want 1/011/10", i, alloc_valid, alloc_slot_en, alloc_preg[0]);
            end
        end
        checks++;
        if (stall_cycles !== 16'd6) begin
            failures++; $display("FAIL bp_stall got=%0d want 6", stall_cycles);
        end
        alloc_ready = 1'b1;
        #1; checks++;
        if (disp_grant !== 3'b111 || DispatchEN !== 3'b111) begin
            failures++; $display("FAIL bp_resume grant=%b pop=%b want 111/111", disp_grant, DispatchEN);
        end
        tick();
        disp_valid = 3'b000;
        checks++;
        if (alloc_valid !== 1'b1 || alloc_slot_en !== 3'b111 || alloc_preg[2] !== 6'd12) begin
            failures++; $display("FAIL bp_resume_out v=%b en=%b p2=%0d want 1/111/12", alloc_valid, alloc_slot_en, alloc_preg[2]);
        end
    endtask

    task automatic test_recover();
        alloc_ready = 1'b0; recover_req = 1'b1;
        tick();
        recover_req = 1'b0; alloc_ready = 1'b1; disp_valid = 3'b111;
        for (int i = 0; i < 3; i++) begin
            #1; checks++;
            if (recover_busy !== 1'b1 || BPRecoverEN !== (i == 0) || disp_grant !== 3'b000 || alloc_valid !== 1'b0) begin
                failures++; $display("FAIL rec_cycle[%0d] busy=%b bp=%b grant=%b v=%b want 1/%0d/000/0",
                                     i, recover_busy, BPRecoverEN, disp_grant, alloc_valid, (i == 0));
            end
            tick();
        end
        checks++;
        if (recover_busy !== 1'b0 || disp_grant !== 3'b111) begin
            failures++; $display("FAIL rec_exit busy=%b grant=%b want 0/111", recover_busy, disp_grant);
        end
    endtask

    task automatic test_back_to_back_recover();
        // Recovery request coincides with a grant: grant visible, output flushed.
        recover_req = 1'b1;
        #1; checks++;
        if (disp_grant !== 3'b111) begin
            failures++; $display("FAIL simul_grant got=%b want 111", disp_grant);
        end
        tick();
        recover_req = 1'b0;
        checks++;
        if (alloc_valid !== 1'b0 || BPRecoverEN !== 1'b1 || recover_busy !== 1'b1) begin
            failures++; $display("FAIL simul_flush v=%b bp=%b busy=%b want 0/1/1", alloc_valid, BPRecoverEN, recover_busy);
        end
        tick();
        recover_req = 1'b1;
        tick();
        recover_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (recover_busy !== 1'b1 || BPRecoverEN !== (i == 0)) begin
                failures++; $display("FAIL rerec[%0d] busy=%b bp=%b want 1/%0d", i, recover_busy, BPRecoverEN, (i == 0));
            end
            tick();
        end
        checks++;
        if (recover_busy !== 1'b0 || BPRecoverEN !== 1'b0) begin
            failures++; $display("FAIL rerec_exit busy=%b bp=%b want 0/0", recover_busy, BPRecoverEN);
        end
    endtask

    task automatic test_async_reset();
        disp_valid = 3'b000; recover_req = 1'b1;
        tick();
        recover_req = 1'b0;
        reset = 1'b0;
        #1; checks++;
        if ({BPRecoverEN, recover_busy, alloc_valid, alloc_slot_en, disp_grant, DispatchEN} !== 12'b0 ||
            alloc_preg !== '0 || stall_cycles !== 16'd0) begin
            failures++; $display("FAIL async_rst bp=%b busy=%b en=%b preg=%h stall=%0d want all 0",
                                 BPRecoverEN, recover_busy, alloc_slot_en, alloc_preg, stall_cycles);
        end
        tick();
        reset = 1'b1; disp_valid = 3'b111;
        #1; checks++;
        if (disp_grant !== 3'b000 || recover_busy !== 1'b0) begin
            failures++; $display("FAIL post_rst_init grant=%b busy=%b want 000/0", disp_grant, recover_busy);
        end
        tick(); tick();
        checks++;
        if (disp_grant !== 3'b111) begin
            failures++; $display("FAIL post_rst_run grant=%b want 111", disp_grant);
        end
    endtask

    task automatic test_grant_patterns();
        logic [2:0] vv [5];
        logic [2:0] nd [5];
        logic [2:0] fv [5];
        logic [2:0] eg [5];
        logic [2:0] ep [5];
        vv = '{3'b111, 3'b111, 3'b111, 3'b010, 3'b011};
        nd = '{3'b110, 3'b111, 3'b111, 3'b010, 3'b010};
        fv = '{3'b000, 3'b011, 3'b101, 3'b111, 3'b011};
        eg = '{3'b001, 3'b011, 3'b001, 3'b000, 3'b011};
        ep = '{3'b000, 3'b011, 3'b001, 3'b000, 3'b001};
        for (int i = 0; i < 5; i++) begin
            disp_valid = vv[i]; disp_needs_dest = nd[i]; FreeRegValid = fv[i];
            #1; checks++;
            if (disp_grant !== eg[i] || DispatchEN !== ep[i]) begin
                failures++; $display("FAIL pattern[%0d] grant=%b pop=%b want %b/%b", i, disp_grant, DispatchEN, eg[i], ep[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_partial();
        test_backpressure();
        test_recover();
        test_back_to_back_recover();
        test_async_reset();
        test_grant_patterns();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/freelist_alloc_ctrl.md
Name: freelist_alloc_ctrl

Overview:
- Allocation controller between the 3-wide dispatch stage and the Freelist.
- Each cycle it decides which dispatch slots may proceed, given the free physical registers the Freelist offers. It drives the Freelist DispatchEN pops and hands the granted PR tags to rename through a one-entry registered output stage.
- It also sequences branch-mispredict recovery: it pulses BPRecoverEN to the Freelist and blocks allocation for a fixed settle window.

Parameters:
- INIT_CYCLES, 2, cycles after reset deassertion before the first grant (Freelist init time).
- RECOVER_LAT, 3, cycles allocation stays blocked after the BPRecoverEN pulse.
- PR_W, `PR`, physical register tag width.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- disp_valid  in  3  slot k holds an instruction.
- disp_needs_dest  in  3  slot k writes a destination register; ignored when disp_valid[k]=0.
- disp_grant  out  3  combinational; slot k accepted this cycle.
- FreeReg  in  3xPR_W  free PR tags offered by the Freelist, oldest at index 0.
- FreeRegValid  in  3  offer valid; contiguous from bit 0.
- DispatchEN  out  3  combinational pop request to the Freelist; bit k pops FreeReg[k].
- BPRecoverEN  out  1  registered one-cycle recovery pulse to the Freelist.
- recover_req  in  1  mispredict recovery request from the ROB.
- alloc_valid  out  1  registered output stage holds a grant group.
- alloc_ready  in  1  rename stage accepts the group.
- alloc_slot_en  out  3  registered copy of disp_grant.
- alloc_preg  out  3xPR_W  registered PR tag per slot; 0 for slots with no dest or no grant.
- recover_busy  out  1  state is RECOVER.
- stall_cycles  out  STALL_CNT_W  saturating count of blocked cycles.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=INIT, counter loaded with INIT_CYCLES.
  - alloc_valid=0, alloc_slot_en=0, alloc_preg=0, BPRecoverEN=0, stall_cycles=0.
  - Combinational outputs are 0 while in INIT.
- FSM:
  - INIT: counter decrements each cycle; at 0 go to RUN.
  - RUN: normal allocation.
  - RECOVER: counter decrements each cycle; at 0 go to RUN.
  - recover_req=1 in any non-INIT state, sampled at the clock edge:
    - next cycle BPRecoverEN=1 for exactly one cycle;
    - state=RECOVER, counter=RECOVER_LAT;
    - alloc_valid cleared (flush), regardless of alloc_ready.
  - recover_req during RECOVER re-pulses BPRecoverEN and reloads the counter.
  - recover_req in INIT is ignored.
- Grant rule (combinational, RUN only):
  - can_issue = !alloc_valid || alloc_ready.
  - F = number of leading ones in FreeRegValid (0..3).
  - Slot k is granted iff can_issue, disp_valid[k], every slot j<k is granted, and the running count of needs_dest over granted slots 0..k is <= F.
  - Grants form an in-order prefix: a blocked slot blocks all higher slots.
  - If the n-th dest-needing granted slot (in order) is slot k, then alloc_preg[k] takes FreeReg[n-1].
  - DispatchEN = thermometer of the total dests consumed (0→000, 1→001, 2→011, 3→111).
  - Outside RUN: disp_grant=0 and DispatchEN=0.
- Output stage, updated on the rising edge:
  - If any grant: alloc_valid=1, alloc_slot_en=disp_grant, alloc_preg loaded.
  - Else if alloc_ready: alloc_valid=0.
  - Else: hold all output-stage values.
  - Recovery flush has priority over both.
- stall_cycles increments when any disp_valid bit is set and disp_grant != disp_valid. It saturates at all-ones.
- Simultaneous events:
  - recover_req in the same cycle as a grant: the grant is still emitted combinationally. The Freelist pops are undone by its recovery, and alloc_valid is flushed.

Test Plan:
- Reset low 2 cycles, release, disp_valid=111, FreeRegValid=111 → grants stay 0 for 2 cycles, then disp_grant=111 and DispatchEN=111; next cycle alloc_preg={FreeReg2,FreeReg1,FreeReg0}.
- disp_valid=111, needs_dest=101, FreeRegValid=001 → disp_grant=011, DispatchEN=001, alloc_preg[0]=FreeReg[0], alloc_preg[1]=0; stall_cycles +1.
- alloc_valid=1, alloc_ready=0 for 3 cycles → disp_grant=0, DispatchEN=0, output stage held; raise alloc_ready → grants resume the same cycle.
- recover_req pulse in RUN → BPRecoverEN=1 for exactly 1 cycle, alloc_valid=0, recover_busy=1 for 3 cycles, grants 0 throughout, then RUN.
- Second recover_req 1 cycle into RECOVER → second BPRecoverEN pulse, recover_busy lasts 3 cycles after it.
- Assert reset mid-RECOVER → all outputs 0 immediately (asynchronous), state INIT after release.
